// File: rtl/reorder_buffer_if.sv
// Bundle of the issue, CDB, query, commit and flush signals around the
// reorder buffer. The master side is the issue/rename/execute
// environment; the slave side is the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    logic              alloc_valid;
    logic              alloc_has_dest;
    logic [4:0]        alloc_rd;
    logic [TAG_W-1:0]  alloc_tag;
    logic              full;
    logic              empty;
    logic [4:0]        count;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic [TAG_W-1:0]  query_tag;
    logic              query_ready;
    logic [DATA_W-1:0] query_data;

    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [4:0]        commit_rd;
    logic              commit_has_dest;
    logic [DATA_W-1:0] commit_data;

    logic              flush;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_rd,
        output cdb_valid, cdb_tag, cdb_data,
        output query_tag, flush,
        input  alloc_tag, full, empty, count,
        input  query_ready, query_data,
        input  commit_valid, commit_tag, commit_rd, commit_has_dest, commit_data
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_rd,
        input  cdb_valid, cdb_tag, cdb_data,
        input  query_tag, flush,
        output alloc_tag, full, empty, count,
        output query_ready, query_data,
        output commit_valid, commit_tag, commit_rd, commit_has_dest, commit_data
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out tags at the tail, captures CDB
// results out of order, and retires the head entry in program order at
// most once per cycle. Full and empty are told apart by the count, since
// head == tail in both cases.
module reorder_buffer #(
    parameter int               DEPTH  = 16,
    parameter int               TAG_W  = 5,
    parameter int               DATA_W = 32,
    parameter logic [TAG_W-1:0] NONE   = 5'b11111
) (
    input  logic              clk,
    input  logic              rst_n,
    reorder_buffer_if.slave   bus
);
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(DEPTH - 1);
    localparam logic [4:0]       DEPTH_CNT = 5'(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_has_dest;
    logic [4:0]        r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [4:0]        r_count;

    logic              r_commit_valid;
    logic [TAG_W-1:0]  r_commit_tag;
    logic [4:0]        r_commit_rd;
    logic              r_commit_has_dest;
    logic [DATA_W-1:0] r_commit_data;

    logic              w_full;
    logic              w_empty;
    logic              w_alloc;
    logic              w_commit;
    logic              w_cdb_in_range;
    logic              w_q_in_range;
    logic              w_wb;
    logic [PTR_W-1:0]  w_cdb_idx;
    logic [PTR_W-1:0]  w_q_idx;
    logic              w_query_ready;
    logic [DATA_W-1:0] w_query_data;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty   = (r_count == 5'd0);
    // An allocation is judged against the current count only, so a
    // same-cycle commit cannot make room for it.
    assign w_alloc   = bus.alloc_valid && !w_full;
    assign w_commit  = r_busy[r_head] && r_done[r_head];

    // NONE and out-of-range tags never name a real entry.
    assign w_cdb_in_range = (bus.cdb_tag <= LAST_TAG) && (bus.cdb_tag != NONE);
    assign w_q_in_range   = (bus.query_tag <= LAST_TAG) && (bus.query_tag != NONE);
    assign w_cdb_idx      = bus.cdb_tag[PTR_W-1:0];
    assign w_q_idx        = bus.query_tag[PTR_W-1:0];
    // Free entries and already-done entries drop the broadcast, so a
    // repeated result cannot overwrite the value a consumer already saw.
    assign w_wb = bus.cdb_valid && w_cdb_in_range
                  && r_busy[w_cdb_idx] && !r_done[w_cdb_idx];

    // Entry state, pointers, count and registered commit port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy            <= '0;
            r_done            <= '0;
            r_has_dest        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_commit_valid    <= 1'b0;
            r_commit_tag      <= '0;
            r_commit_rd       <= '0;
            r_commit_has_dest <= 1'b0;
            r_commit_data     <= '0;
        end else if (bus.flush) begin
            r_busy         <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_tag      <= TAG_W'(r_head);
                r_commit_rd       <= r_rd[r_head];
                r_commit_has_dest <= r_has_dest[r_head];
                r_commit_data     <= r_data[r_head];
                r_busy[r_head]    <= 1'b0;
                r_head            <= r_head + 1'b1;
            end
            // The tail entry is never busy when an allocation is accepted,
            // so it cannot collide with the commit or writeback above.
            if (w_alloc) begin
                r_busy[r_tail]     <= 1'b1;
                r_done[r_tail]     <= 1'b0;
                r_has_dest[r_tail] <= bus.alloc_has_dest;
                r_rd[r_tail]       <= bus.alloc_rd;
                r_tail             <= r_tail + 1'b1;
            end
            if (w_wb) begin
                r_done[w_cdb_idx] <= 1'b1;
                r_data[w_cdb_idx] <= bus.cdb_data;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand lookup: a matching CDB broadcast this cycle beats the stored entry.
    always_comb begin
        w_query_ready = 1'b0;
        w_query_data  = r_data[w_q_idx];
        if (bus.cdb_valid && w_cdb_in_range && (bus.cdb_tag == bus.query_tag)) begin
            w_query_ready = 1'b1;
            w_query_data  = bus.cdb_data;
        end else if (w_q_in_range) begin
            w_query_ready = r_busy[w_q_idx] && r_done[w_q_idx];
        end
    end

    assign bus.alloc_tag       = TAG_W'(r_tail);
    assign bus.full            = w_full;
    assign bus.empty           = w_empty;
    assign bus.count           = r_count;
    assign bus.query_ready     = w_query_ready;
    assign bus.query_data      = w_query_data;
    assign bus.commit_valid    = r_commit_valid;
    assign bus.commit_tag      = r_commit_tag;
    assign bus.commit_rd       = r_commit_rd;
    assign bus.commit_has_dest = r_commit_has_dest;
    assign bus.commit_data     = r_commit_data;
endmodule
